// File: rtl/rv_dmem_resp_if.sv
// Bus bundle between the execute stage, the data-memory responder and the
// I/O peripheral port. Signal suffixes are from the responder's point of view.
interface rv_dmem_resp_if;
    logic [31:0] dm_addr_i;
    logic [31:0] dm_data_s_i;
    logic [3:0]  dm_data_select_i;
    logic        dm_write_i;
    logic        dm_load_i;
    logic [31:0] dm_data_l_o;
    logic        dm_load_done_o;
    logic        dm_stall_req_o;
    logic [31:0] io_addr_o;
    logic [31:0] io_data_o;
    logic [3:0]  io_sel_o;
    logic        io_we_o;
    logic        io_req_o;
    logic        io_ack_i;
    logic [31:0] io_data_i;
    logic        io_err_o;

    modport slave (
        input  dm_addr_i, dm_data_s_i, dm_data_select_i, dm_write_i, dm_load_i,
        input  io_ack_i, io_data_i,
        output dm_data_l_o, dm_load_done_o, dm_stall_req_o,
        output io_addr_o, io_data_o, io_sel_o, io_we_o, io_req_o, io_err_o
    );

    modport master (
        output dm_addr_i, dm_data_s_i, dm_data_select_i, dm_write_i, dm_load_i,
        output io_ack_i, io_data_i,
        input  dm_data_l_o, dm_load_done_o, dm_stall_req_o,
        input  io_addr_o, io_data_o, io_sel_o, io_we_o, io_req_o, io_err_o
    );
endinterface

// File: rtl/rv_dmem_resp.sv
// Data-memory responder: single-cycle internal RAM plus a stalling I/O port.
// Optional I/O wait timeout is enabled with `define RV_DMEM_TIMEOUT_EN.
module rv_dmem_resp #(
    parameter int          ADDR_WIDTH     = 12,
    parameter logic [3:0]  IO_NIBBLE      = 4'h8,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    rv_dmem_resp_if.slave  dm
);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_IO_WAIT = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [31:0]           io_addr_q, io_addr_d;
    logic [31:0]           io_data_q, io_data_d;
    logic [3:0]            io_sel_q, io_sel_d;
    logic                  io_we_q, io_we_d;
    logic                  io_req_q, io_req_d;
    logic                  pend_load_q, pend_load_d;
    logic [31:0]           data_l_q, data_l_d;
    logic                  done_q, done_d;
    logic                  from_ram_q, from_ram_d;
    logic                  err_d;
    logic                  stall;
    logic                  ram_we;
    logic                  ram_re;
    logic [31:0]           ram_rd_q;
    logic [ADDR_WIDTH-1:0] ram_idx;
    logic                  strobe;
    logic                  io_hit;

    logic [31:0] mem [2**ADDR_WIDTH];

    assign strobe  = dm.dm_write_i | dm.dm_load_i;
    assign io_hit  = (dm.dm_addr_i[31:28] == IO_NIBBLE);
    assign ram_idx = dm.dm_addr_i[ADDR_WIDTH+1:2];

`ifdef RV_DMEM_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES >= 256) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    // NOTE: every variable assigned here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        io_addr_d   = io_addr_q;
        io_data_d   = io_data_q;
        io_sel_d    = io_sel_q;
        io_we_d     = io_we_q;
        io_req_d    = io_req_q;
        pend_load_d = pend_load_q;
        data_l_d    = data_l_q;
        from_ram_d  = from_ram_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        stall       = 1'b0;
        ram_we      = 1'b0;
        ram_re      = 1'b0;
`ifdef RV_DMEM_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (strobe && io_hit) begin
                    stall       = 1'b1;
                    io_addr_d   = dm.dm_addr_i;
                    io_data_d   = dm.dm_data_s_i;
                    io_sel_d    = dm.dm_data_select_i;
                    io_we_d     = dm.dm_write_i;
                    pend_load_d = ~dm.dm_write_i;
                    io_req_d    = 1'b1;
                    state_d     = ST_IO_WAIT;
`ifdef RV_DMEM_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                end else if (dm.dm_write_i) begin
                    ram_we = 1'b1;
                end else if (dm.dm_load_i) begin
                    ram_re     = 1'b1;
                    from_ram_d = 1'b1;
                    done_d     = 1'b1;
                end
            end

            ST_IO_WAIT: begin
                // Strobes here are the stalled core re-presenting the same op.
                stall = ~dm.io_ack_i;
                if (dm.io_ack_i) begin
                    state_d     = ST_IDLE;
                    io_req_d    = 1'b0;
                    pend_load_d = 1'b0;
                    if (pend_load_q) begin
                        data_l_d   = dm.io_data_i;
                        from_ram_d = 1'b0;
                        done_d     = 1'b1;
                    end
                end
`ifdef RV_DMEM_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    stall       = 1'b0;
                    state_d     = ST_IDLE;
                    io_req_d    = 1'b0;
                    pend_load_d = 1'b0;
                    err_d       = 1'b1;
                    if (pend_load_q) begin
                        data_l_d   = 32'hFFFF_FFFF;
                        from_ram_d = 1'b0;
                        done_d     = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            io_addr_q   <= '0;
            io_data_q   <= '0;
            io_sel_q    <= '0;
            io_we_q     <= 1'b0;
            io_req_q    <= 1'b0;
            pend_load_q <= 1'b0;
            data_l_q    <= '0;
            done_q      <= 1'b0;
            from_ram_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            io_addr_q   <= io_addr_d;
            io_data_q   <= io_data_d;
            io_sel_q    <= io_sel_d;
            io_we_q     <= io_we_d;
            io_req_q    <= io_req_d;
            pend_load_q <= pend_load_d;
            data_l_q    <= data_l_d;
            done_q      <= done_d;
            from_ram_q  <= from_ram_d;
        end
    end

`ifdef RV_DMEM_TIMEOUT_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign dm.io_err_o = err_q;
`else
    logic unused_err;
    assign unused_err  = err_d;
    assign dm.io_err_o = 1'b0;
`endif

    // NOTE: the RAM array and its read register carry no reset so they map
    // onto block RAM; the output mux below keeps the port at 0 after reset.
    always_ff @(posedge clk_i) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (dm.dm_data_select_i[b]) begin
                    mem[ram_idx][8*b +: 8] <= dm.dm_data_s_i[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (ram_re) begin
            ram_rd_q <= mem[ram_idx];
        end
    end

    assign dm.dm_data_l_o    = from_ram_q ? ram_rd_q : data_l_q;
    assign dm.dm_load_done_o = done_q;
    // Gated by reset so an abandoned I/O request releases the core at once.
    assign dm.dm_stall_req_o = rst_n_i & stall;
    assign dm.io_addr_o      = io_addr_q;
    assign dm.io_data_o      = io_data_q;
    assign dm.io_sel_o       = io_sel_q;
    assign dm.io_we_o        = io_we_q;
    assign dm.io_req_o       = io_req_q;

endmodule

// File: tb/tb_rv_dmem_resp.sv
// Directed bench for rv_dmem_resp: RAM stores/loads, aliasing, I/O handshake,
// async reset mid-transaction and (with RV_DMEM_TIMEOUT_EN) the I/O timeout.
module tb_rv_dmem_resp;

`ifdef RV_DMEM_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 255;
`endif

    logic clk_i = 1'b0;
    logic rst_n_i;
    int   checks = 0;
    int   errors = 0;

    always #5 clk_i = ~clk_i;

    rv_dmem_resp_if dm_if ();

    rv_dmem_resp #(
        .ADDR_WIDTH    (12),
        .IO_NIBBLE     (4'h8),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i  (clk_i),
        .rst_n_i(rst_n_i),
        .dm     (dm_if)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic sample();
        @(negedge clk_i);
    endtask

    task automatic bus(input logic wr, input logic ld, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] sel);
        dm_if.dm_write_i       = wr;
        dm_if.dm_load_i        = ld;
        dm_if.dm_addr_i        = addr;
        dm_if.dm_data_s_i      = data;
        dm_if.dm_data_select_i = sel;
    endtask

    task automatic bus_idle();
        bus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    initial begin
        rst_n_i        = 1'b0;
        bus_idle();
        dm_if.io_ack_i  = 1'b0;
        dm_if.io_data_i = 32'h0;

        #12;
        check("rst_stall",  32'(dm_if.dm_stall_req_o), 32'h0);
        check("rst_done",   32'(dm_if.dm_load_done_o), 32'h0);
        check("rst_data_l", dm_if.dm_data_l_o,         32'h0);
        check("rst_io_req", 32'(dm_if.io_req_o),       32'h0);
        check("rst_io_adr", dm_if.io_addr_o,           32'h0);
        check("rst_io_err", 32'(dm_if.io_err_o),       32'h0);
        next_cycle();
        next_cycle();
        rst_n_i = 1'b1;

        // Full-word store, byte-lane store, then load the merged word
        bus(1'b1, 1'b0, 32'h010, 32'h1122_3344, 4'b1111);
        sample();
        check("st_full_stall", 32'(dm_if.dm_stall_req_o), 32'h0);
        next_cycle();
        bus(1'b1, 1'b0, 32'h011, 32'hAAAA_AAAA, 4'b0010);
        sample();
        check("st_byte_stall", 32'(dm_if.dm_stall_req_o), 32'h0);
        check("st_no_done",    32'(dm_if.dm_load_done_o), 32'h0);
        next_cycle();
        bus(1'b0, 1'b1, 32'h010, 32'h0, 4'h0);
        sample();
        check("ld_n_stall", 32'(dm_if.dm_stall_req_o), 32'h0);
        check("ld_n_done",  32'(dm_if.dm_load_done_o), 32'h0);
        next_cycle();
        bus_idle();
        sample();
        check("ld_n1_done", 32'(dm_if.dm_load_done_o), 32'h1);
        check("ld_n1_data", dm_if.dm_data_l_o,         32'h1122_AA44);
        next_cycle();
        sample();
        check("ld_n2_done", 32'(dm_if.dm_load_done_o), 32'h0);

        // Address alias modulo RAM size
        bus(1'b1, 1'b0, 32'h0000_4000, 32'hCAFE_F00D, 4'b1111);
        next_cycle();
        bus(1'b0, 1'b1, 32'h0000_0000, 32'h0, 4'h0);
        next_cycle();
        bus_idle();
        sample();
        check("alias_done", 32'(dm_if.dm_load_done_o), 32'h1);
        check("alias_data", dm_if.dm_data_l_o,         32'hCAFE_F00D);

        // Read-after-write, then back-to-back loads
        next_cycle();
        bus(1'b1, 1'b0, 32'h020, 32'h1234_5678, 4'b1111);
        next_cycle();
        bus(1'b0, 1'b1, 32'h020, 32'h0, 4'h0);
        next_cycle();
        bus(1'b0, 1'b1, 32'h010, 32'h0, 4'h0);
        sample();
        check("raw_done", 32'(dm_if.dm_load_done_o), 32'h1);
        check("raw_data", dm_if.dm_data_l_o,         32'h1234_5678);
        next_cycle();
        bus_idle();
        sample();
        check("b2b_done", 32'(dm_if.dm_load_done_o), 32'h1);
        check("b2b_data", dm_if.dm_data_l_o,         32'h1122_AA44);
        next_cycle();
        sample();
        check("b2b_end", 32'(dm_if.dm_load_done_o), 32'h0);

        // Store wins over a simultaneous load
        bus(1'b1, 1'b1, 32'h030, 32'h0BAD_BEEF, 4'b1111);
        next_cycle();
        bus(1'b0, 1'b1, 32'h030, 32'h0, 4'h0);
        sample();
        check("wr_wins_no_done", 32'(dm_if.dm_load_done_o), 32'h0);
        next_cycle();
        bus_idle();
        sample();
        check("wr_wins_data", dm_if.dm_data_l_o, 32'h0BAD_BEEF);

        // Stray ack in IDLE is ignored
        next_cycle();
        dm_if.io_ack_i  = 1'b1;
        dm_if.io_data_i = 32'h7777_7777;
        sample();
        check("idle_ack_stall", 32'(dm_if.dm_stall_req_o), 32'h0);
        next_cycle();
        dm_if.io_ack_i  = 1'b0;
        dm_if.io_data_i = 32'h0;
        sample();
        check("idle_ack_done", 32'(dm_if.dm_load_done_o), 32'h0);
        check("idle_ack_req",  32'(dm_if.io_req_o),       32'h0);

        // I/O load acked at N+3
        next_cycle();
        bus(1'b0, 1'b1, 32'h8000_0004, 32'h0, 4'h0);
        sample();
        check("iold_n_stall", 32'(dm_if.dm_stall_req_o), 32'h1);
        check("iold_n_req",   32'(dm_if.io_req_o),       32'h0);
        next_cycle();
        sample();
        check("iold_n1_stall", 32'(dm_if.dm_stall_req_o), 32'h1);
        check("iold_n1_req",   32'(dm_if.io_req_o),       32'h1);
        check("iold_n1_addr",  dm_if.io_addr_o,           32'h8000_0004);
        check("iold_n1_we",    32'(dm_if.io_we_o),        32'h0);
        next_cycle();
        sample();
        check("iold_n2_stall", 32'(dm_if.dm_stall_req_o), 32'h1);
        check("iold_n2_req",   32'(dm_if.io_req_o),       32'h1);
        next_cycle();
        dm_if.io_ack_i  = 1'b1;
        dm_if.io_data_i = 32'h5A5A_0001;
        sample();
        check("iold_n3_stall", 32'(dm_if.dm_stall_req_o), 32'h0);
        check("iold_n3_req",   32'(dm_if.io_req_o),       32'h1);
        check("iold_n3_done",  32'(dm_if.dm_load_done_o), 32'h0);
        next_cycle();
        bus_idle();
        dm_if.io_ack_i  = 1'b0;
        dm_if.io_data_i = 32'h0;
        sample();
        check("iold_n4_done",  32'(dm_if.dm_load_done_o), 32'h1);
        check("iold_n4_data",  dm_if.dm_data_l_o,         32'h5A5A_0001);
        check("iold_n4_req",   32'(dm_if.io_req_o),       32'h0);
        check("iold_n4_stall", 32'(dm_if.dm_stall_req_o), 32'h0);
        next_cycle();
        sample();
        check("iold_n5_done", 32'(dm_if.dm_load_done_o), 32'h0);

        // I/O store acked after one wait cycle, then a RAM load
        bus(1'b1, 1'b0, 32'h8000_0010, 32'hDEAD_0000, 4'b1100);
        sample();
        check("iost_n_stall", 32'(dm_if.dm_stall_req_o), 32'h1);
        next_cycle();
        dm_if.io_ack_i = 1'b1;
        sample();
        check("iost_n1_stall", 32'(dm_if.dm_stall_req_o), 32'h0);
        check("iost_n1_req",   32'(dm_if.io_req_o),       32'h1);
        check("iost_n1_we",    32'(dm_if.io_we_o),        32'h1);
        check("iost_n1_sel",   32'(dm_if.io_sel_o),       32'hC);
        check("iost_n1_data",  dm_if.io_data_o,           32'hDEAD_0000);
        check("iost_n1_addr",  dm_if.io_addr_o,           32'h8000_0010);
        next_cycle();
        bus_idle();
        dm_if.io_ack_i = 1'b0;
        sample();
        check("iost_n2_req",  32'(dm_if.io_req_o),       32'h0);
        check("iost_n2_done", 32'(dm_if.dm_load_done_o), 32'h0);
        next_cycle();
        bus(1'b0, 1'b1, 32'h010, 32'h0, 4'h0);
        next_cycle();
        bus_idle();
        sample();
        check("post_io_done", 32'(dm_if.dm_load_done_o), 32'h1);
        check("post_io_data", dm_if.dm_data_l_o,         32'h1122_AA44);

`ifdef RV_DMEM_TIMEOUT_EN
        // I/O load never acked: timeout after 8 wait cycles
        next_cycle();
        bus(1'b0, 1'b1, 32'h8000_0008, 32'h0, 4'h0);
        for (int i = 1; i <= 7; i++) begin
            next_cycle();
            sample();
            check("tmo_wait_stall", 32'(dm_if.dm_stall_req_o), 32'h1);
            check("tmo_wait_err",   32'(dm_if.io_err_o),       32'h0);
        end
        next_cycle();
        sample();
        check("tmo_last_stall", 32'(dm_if.dm_stall_req_o), 32'h0);
        check("tmo_last_req",   32'(dm_if.io_req_o),       32'h1);
        check("tmo_last_err",   32'(dm_if.io_err_o),       32'h0);
        next_cycle();
        bus_idle();
        sample();
        check("tmo_err",  32'(dm_if.io_err_o),       32'h1);
        check("tmo_done", 32'(dm_if.dm_load_done_o), 32'h1);
        check("tmo_data", dm_if.dm_data_l_o,         32'hFFFF_FFFF);
        check("tmo_req",  32'(dm_if.io_req_o),       32'h0);
        next_cycle();
        sample();
        check("tmo_err_end",  32'(dm_if.io_err_o),       32'h0);
        check("tmo_done_end", 32'(dm_if.dm_load_done_o), 32'h0);
`endif

        // Async reset while waiting on the peripheral
        next_cycle();
        bus(1'b0, 1'b1, 32'h8000_0004, 32'h0, 4'h0);
        next_cycle();
        sample();
        check("rstio_n1_req", 32'(dm_if.io_req_o), 32'h1);
        next_cycle();
        sample();
        check("rstio_n2_stall", 32'(dm_if.dm_stall_req_o), 32'h1);
        #2;
        rst_n_i = 1'b0;
        #1;
        check("rstio_req",   32'(dm_if.io_req_o),       32'h0);
        check("rstio_stall", 32'(dm_if.dm_stall_req_o), 32'h0);
        check("rstio_addr",  dm_if.io_addr_o,           32'h0);
        bus_idle();
        next_cycle();
        next_cycle();
        rst_n_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            sample();
            check("rstio_post_done", 32'(dm_if.dm_load_done_o), 32'h0);
            check("rstio_post_req",  32'(dm_if.io_req_o),       32'h0);
        end

        // RAM contents survive reset
        bus(1'b0, 1'b1, 32'h010, 32'h0, 4'h0);
        next_cycle();
        bus_idle();
        sample();
        check("ram_keep_done", 32'(dm_if.dm_load_done_o), 32'h1);
        check("ram_keep_data", dm_if.dm_data_l_o,         32'h1122_AA44);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv_dmem_resp.md
Name: rv_dmem_resp

Overview:
- Data-memory responder: the slave end of the execute stage's dm interface (address, store data, byte select, write strobe), plus a load request.
- Serves two regions:
  - Internal RAM: single-cycle, no stall.
  - I/O region: forwarded to an external request/acknowledge port, holding the pipeline via a stall request until the peripheral acknowledges.
- Load data is returned one cycle after acceptance, aligned with the writeback stage's load capture.

Parameters:
- ADDR_WIDTH, 12, word-address bits of internal RAM (depth = 2**ADDR_WIDTH words of 32 bits).
- IO_NIBBLE, 4'h8, value of dm_addr_i[31:28] that selects the I/O region.
- TIMEOUT_CYCLES, 255, I/O wait limit in cycles; used only with RV_DMEM_TIMEOUT_EN.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  reset; asynchronous assert, active-low.
- dm_addr_i  in  32  byte address from execute stage.
- dm_data_s_i  in  32  store data, already byte-replicated by the initiator.
- dm_data_select_i  in  4  byte enables.
- dm_write_i  in  1  store strobe, one cycle per accepted store.
- dm_load_i  in  1  load strobe, one cycle per accepted load.
- dm_data_l_o  out  32  load data, full word (writeback stage extracts and extends).
- dm_load_done_o  out  1  one-cycle pulse; dm_data_l_o valid.
- dm_stall_req_o  out  1  pipeline stall request.
- io_addr_o  out  32  I/O address (registered).
- io_data_o  out  32  I/O write data (registered).
- io_sel_o  out  4  I/O byte enables (registered).
- io_we_o  out  1  I/O write.
- io_req_o  out  1  I/O request, held until acknowledged.
- io_ack_i  in  1  I/O acknowledge, single cycle.
- io_data_i  in  32  I/O read data, valid with io_ack_i.
- io_err_o  out  1  timeout pulse; tied 0 when the optional feature is off.

Behaviour:
- Reset (rst_n_i low, asynchronous):
  - All outputs go to 0; FSM goes to IDLE; timeout counter cleared.
  - RAM contents are not reset.
  - Reset mid-I/O abandons the transaction: io_req_o low immediately, no done pulse.
- Request decode:
  - dm_write_i wins when dm_write_i and dm_load_i are both high; the cycle is a store and the load is dropped.
  - io_hit = (dm_addr_i[31:28] == IO_NIBBLE). Anything else is RAM.
  - RAM word index = dm_addr_i[ADDR_WIDTH+1:2]. Upper bits are ignored, so addresses alias/wrap modulo RAM size. Bits [1:0] are ignored; dm_data_select_i carries the lane.
- RAM store: at the clock edge of the strobe cycle, write each byte lane whose select bit is 1. No stall, no done pulse.
- RAM load:
  - Synchronous read at the edge of the strobe cycle N.
  - dm_data_l_o valid and dm_load_done_o = 1 in cycle N+1 only.
  - Load in N+1 of a store at N to the same word returns the written value (read-after-write ordering at the edge).
- I/O FSM states IDLE and IO_WAIT:
  - IDLE, strobe with io_hit:
    - dm_stall_req_o = 1 combinationally in that cycle.
    - Capture address, data, select and we into io_* registers.
    - Go to IO_WAIT; io_req_o = 1 from the next cycle.
  - IO_WAIT:
    - io_req_o held high; io_* registers stable; dm_stall_req_o = !io_ack_i.
    - On io_ack_i: go to IDLE, io_req_o falls next cycle.
    - For loads, latch io_data_i into dm_data_l_o and pulse dm_load_done_o in the following cycle.
    - For stores, there is no done pulse.
  - Strobes arriving while in IO_WAIT are ignored. The core is stalled and holds them; no new request is taken in the ack cycle either.
  - io_ack_i in IDLE is ignored.
- dm_load_done_o is never high on two consecutive cycles except for back-to-back RAM loads.

Optional Feature:
- RV_DMEM_TIMEOUT_EN defined:
  - An 8+ bit counter runs in IO_WAIT and clears on entry.
  - When it reaches TIMEOUT_CYCLES without io_ack_i, the FSM returns to IDLE, io_req_o drops, and io_err_o pulses for 1 cycle.
  - A pending load completes with dm_data_l_o = 32'hFFFFFFFF and a dm_load_done_o pulse the next cycle.
- Undefined: no counter; IO_WAIT persists until io_ack_i; io_err_o tied 0.

Test Plan:
- Full-word RAM store:
  - Store 0x11223344, select 4'b1111, to 0x010.
  - Then byte store 0xAAAAAAAA, select 4'b0010, to 0x011.
  - Then load 0x010 at cycle N -> dm_data_l_o = 0x1122AA44 and done = 1 at N+1 only; stall never asserted.
- RAM alias (ADDR_WIDTH=12): store 0xCAFEF00D to 0x00004000, load 0x00000000 -> 0xCAFEF00D.
- I/O load:
  - Load 0x80000004 at cycle N, io_ack_i at N+3 with io_data_i = 0x5A5A0001.
  - Required: stall high N..N+2, low at N+3; io_req_o high N+1..N+3; io_addr_o = 0x80000004, io_we_o = 0; done with 0x5A5A0001 at N+4.
- I/O store then RAM load:
  - I/O store 0xDEAD0000, select 4'b1100, acked after 1 cycle -> io_we_o = 1, io_sel_o = 4'b1100, no done pulse.
  - Subsequent RAM load serviced normally.
- Async reset in IO_WAIT: drop rst_n_i two cycles after I/O request -> io_req_o and stall go 0 without a clock edge; no done pulse after release.
- With RV_DMEM_TIMEOUT_EN, TIMEOUT_CYCLES=8: I/O load, no ack -> io_err_o pulse after 8 wait cycles; done with 0xFFFFFFFF next cycle; FSM back in IDLE.
